// File: rtl/hs32_alu_seq_pkg.sv
// Shared HS32 ALU definitions: opcodes, NZCV bit positions and sequencer states.
package hs32_alu_seq_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_ADC = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_BIC = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8;
    localparam logic [3:0] OP_SHL = 4'd9;
    localparam logic [3:0] OP_SHR = 4'd10;
    localparam logic [3:0] OP_ASR = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12;

    localparam int FL_N = 3;
    localparam int FL_Z = 2;
    localparam int FL_C = 1;
    localparam int FL_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/hs32_alu_mul_iter.sv
// Iterative shift-add multiplier retiring MUL_STEP bits of b per cycle.
// done/p are combinational on the cycle the final step is applied.
module hs32_alu_mul_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int STEPS = WIDTH / MUL_STEP;
    localparam int CW    = $clog2(STEPS);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] pp;

    always_comb begin
        pp = '0;
        for (int i = 0; i < MUL_STEP; i++) begin
            if (b_q[i]) pp = pp + (a_q << i);
        end
    end

    assign p    = acc + pp;
    assign done = busy && (cnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= 1'b0;
            cnt  <= '0;
            a_q  <= '0;
            b_q  <= '0;
            acc  <= '0;
        end else if (clear) begin
            busy <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= CW'(STEPS - 1);
            a_q  <= a;
            b_q  <= b;
            acc  <= '0;
        end else if (busy) begin
            acc <= p;
            a_q <= a_q << MUL_STEP;
            b_q <= b_q >> MUL_STEP;
            cnt <= cnt - 1'b1;
            if (cnt == '0) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/hs32_alu_seq.sv
// Handshaked HS32 ALU with registered result/NZCV and an iterative multiplier.
// state   | meaning
// IDLE    | accepting ops; single-cycle results load directly
// MUL     | multiplier iterating; ready_o held low
module hs32_alu_seq
    import hs32_alu_seq_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       fl_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] r_o,
    output logic [3:0]       fl_o
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    logic [3:0]       fl_mul;
    logic             accept;
    logic             mul_done;
    logic [WIDTH-1:0] mul_p;

    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] b_add;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shl_w;
    logic [WIDTH:0]   shr_w;
    logic [WIDTH:0]   asr_w;
    logic [WIDTH-1:0] r_nxt;
    logic             c_nxt;
    logic             v_nxt;
    logic             pass;
    logic [3:0]       fl_nxt;
    logic [3:0]       fl_mul_nxt;

    assign ready_o = (state == ST_IDLE) && (!valid_o || ready_i);
    assign accept  = valid_i && ready_o && !flush_i;
    assign amt     = b_i[SHW-1:0];

    always_comb begin
        b_add = (op_i == OP_SUB || op_i == OP_SBC) ? ~b_i : b_i;
        cin   = (op_i == OP_SUB) ? 1'b1
              : (op_i == OP_ADC || op_i == OP_SBC) ? fl_i[FL_C] : 1'b0;
        sum   = {1'b0, a_i} + {1'b0, b_add} + {{WIDTH{1'b0}}, cin};
        // One spare bit on each shifter catches the last bit shifted out.
        shl_w = {1'b0, a_i} << amt;
        shr_w = {a_i, 1'b0} >> amt;
        asr_w = $signed({a_i, 1'b0}) >>> amt;

        r_nxt = a_i;
        c_nxt = fl_i[FL_C];
        v_nxt = fl_i[FL_V];
        pass  = 1'b0;
        case (op_i)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                r_nxt = sum[WIDTH-1:0];
                c_nxt = sum[WIDTH];
                v_nxt = (a_i[WIDTH-1] == b_add[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
            end
            OP_AND: r_nxt = a_i & b_i;
            OP_OR:  r_nxt = a_i | b_i;
            OP_XOR: r_nxt = a_i ^ b_i;
            OP_BIC: r_nxt = a_i & ~b_i;
            OP_MOV: r_nxt = b_i;
            OP_SHL: begin
                r_nxt = shl_w[WIDTH-1:0];
                if (amt != '0) c_nxt = shl_w[WIDTH];
            end
            OP_SHR: begin
                r_nxt = shr_w[WIDTH:1];
                if (amt != '0) c_nxt = shr_w[0];
            end
            OP_ASR: begin
                r_nxt = asr_w[WIDTH:1];
                if (amt != '0) c_nxt = asr_w[0];
            end
            OP_MUL: r_nxt = a_i;
            default: pass = 1'b1;
        endcase

        if (pass) begin
            fl_nxt = fl_i;
        end else begin
            fl_nxt       = '0;
            fl_nxt[FL_N] = r_nxt[WIDTH-1];
            fl_nxt[FL_Z] = (r_nxt == '0);
            fl_nxt[FL_C] = c_nxt;
            fl_nxt[FL_V] = v_nxt;
        end

        fl_mul_nxt       = '0;
        fl_mul_nxt[FL_N] = mul_p[WIDTH-1];
        fl_mul_nxt[FL_Z] = (mul_p == '0);
        fl_mul_nxt[FL_C] = fl_mul[FL_C];
        fl_mul_nxt[FL_V] = fl_mul[FL_V];
    end

    hs32_alu_mul_iter #(
        .WIDTH    (WIDTH),
        .MUL_STEP (MUL_STEP)
    ) u_mul (
        .clk   (clk),
        .reset (reset),
        .clear (flush_i),
        .start (accept && (op_i == OP_MUL)),
        .a     (a_i),
        .b     (b_i),
        .done  (mul_done),
        .p     (mul_p)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            valid_o <= 1'b0;
            r_o     <= '0;
            fl_o    <= '0;
            fl_mul  <= '0;
        end else if (flush_i) begin
            state   <= ST_IDLE;
            valid_o <= 1'b0;
        end else begin
            if (valid_o && ready_i) valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (op_i == OP_MUL) begin
                            state  <= ST_MUL;
                            fl_mul <= fl_i;
                        end else begin
                            r_o     <= r_nxt;
                            fl_o    <= fl_nxt;
                            valid_o <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        r_o     <= mul_p;
                        fl_o    <= fl_mul_nxt;
                        valid_o <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hs32_alu_seq.sv
// Directed vector bench for hs32_alu_seq (WIDTH=32, MUL_STEP 1 and 4).
module tb_hs32_alu_seq;
    import hs32_alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_i;
    logic        valid_i;
    logic        valid4;
    logic        ready_i;
    logic [3:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [3:0]  fl_i;

    logic        ready_o, valid_o;
    logic [31:0] r_o;
    logic [3:0]  fl_o;
    logic        ready4, vout4;
    logic [31:0] r4;
    logic [3:0]  fl4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hs32_alu_seq #(.WIDTH(32), .MUL_STEP(1)) dut (
        .clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .op_i(op_i), .a_i(a_i), .b_i(b_i), .fl_i(fl_i), .valid_o(valid_o),
        .ready_i(ready_i), .r_o(r_o), .fl_o(fl_o)
    );

    hs32_alu_seq #(.WIDTH(32), .MUL_STEP(4)) dut4 (
        .clk(clk), .reset(reset), .flush_i(flush_i), .valid_i(valid4), .ready_o(ready4),
        .op_i(op_i), .a_i(a_i), .b_i(b_i), .fl_i(fl_i), .valid_o(vout4),
        .ready_i(ready_i), .r_o(r4), .fl_o(fl4)
    );

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  fl;
        logic [31:0] r;
        logic [3:0]  nzcv;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mul_run(input bit use4, input int exp_lat);
        int  lat;
        bit  seen;
        op_i = OP_MUL; a_i = 32'h0001_0000; b_i = 32'h0001_0003; fl_i = 4'b0011;
        if (use4) valid4 = 1'b1; else valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0; valid4 = 1'b0;
        op_i = OP_ADD; fl_i = 4'b0000;
        lat = 0; seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            if (use4 ? vout4 : valid_o) begin
                seen = 1'b1;
            end else begin
                lat++;
                chk("mul ready_o low", {31'b0, use4 ? ready4 : ready_o}, 32'd0);
                @(negedge clk);
            end
        end
        chk(use4 ? "mul4 latency" : "mul1 latency", lat, exp_lat);
        chk(use4 ? "mul4 r" : "mul1 r", use4 ? r4 : r_o, 32'h0003_0000);
        chk(use4 ? "mul4 nzcv" : "mul1 nzcv", {28'b0, use4 ? fl4 : fl_o}, 32'h3);
        @(negedge clk);
    endtask

    initial begin
        int vseen;

        vecs[0]  = '{"add ovf",     OP_ADD, 32'h7FFF_FFFF, 32'h1,          4'b0000, 32'h8000_0000, 4'b1001};
        vecs[1]  = '{"sub eq",      OP_SUB, 32'h5,         32'h5,          4'b0000, 32'h0,         4'b0110};
        vecs[2]  = '{"sub borrow",  OP_SUB, 32'h3,         32'h5,          4'b0000, 32'hFFFF_FFFE, 4'b1000};
        vecs[3]  = '{"adc wrap",    OP_ADC, 32'hFFFF_FFFF, 32'h0,          4'b0010, 32'h0,         4'b0110};
        vecs[4]  = '{"sbc",         OP_SBC, 32'd10,        32'd3,          4'b0000, 32'd6,         4'b0010};
        vecs[5]  = '{"shl 1",       OP_SHL, 32'h8000_0001, 32'd1,          4'b0000, 32'h2,         4'b0010};
        vecs[6]  = '{"asr 31",      OP_ASR, 32'h8000_0000, 32'd31,         4'b0000, 32'hFFFF_FFFF, 4'b1000};
        vecs[7]  = '{"shl 0",       OP_SHL, 32'h1234,      32'd0,          4'b0010, 32'h1234,      4'b0010};
        vecs[8]  = '{"and",         OP_AND, 32'hF0F0,      32'hFF00,       4'b0011, 32'hF000,      4'b0011};
        vecs[9]  = '{"or zero",     OP_OR,  32'h0,         32'h0,          4'b0001, 32'h0,         4'b0101};
        vecs[10] = '{"xor",         OP_XOR, 32'hFFFF_0000, 32'h0000_FFFF,  4'b0000, 32'hFFFF_FFFF, 4'b1000};
        vecs[11] = '{"bic",         OP_BIC, 32'hFF,        32'h0F,         4'b0010, 32'hF0,        4'b0010};
        vecs[12] = '{"mov",         OP_MOV, 32'h1,         32'h8000_0000,  4'b0000, 32'h8000_0000, 4'b1000};
        vecs[13] = '{"shr 4",       OP_SHR, 32'h18,        32'd4,          4'b0000, 32'h1,         4'b0010};
        vecs[14] = '{"op13 pass",   4'd13,  32'h0,         32'h5,          4'b1111, 32'h0,         4'b1111};
        vecs[15] = '{"shl wrap 32", OP_SHL, 32'h5,         32'd32,         4'b0000, 32'h5,         4'b0000};
        vecs[16] = '{"add negovf",  OP_ADD, 32'h8000_0000, 32'h8000_0000,  4'b0000, 32'h0,         4'b0111};
        vecs[17] = '{"sub ovf",     OP_SUB, 32'h8000_0000, 32'h1,          4'b0000, 32'h7FFF_FFFF, 4'b0011};

        reset = 1'b0; flush_i = 1'b0; valid_i = 1'b0; valid4 = 1'b0; ready_i = 1'b1;
        op_i = OP_ADD; a_i = '0; b_i = '0; fl_i = '0;

        #12;
        chk("reset valid_o", {31'b0, valid_o}, 32'd0);
        chk("reset r_o", r_o, 32'd0);
        chk("reset fl_o", {28'b0, fl_o}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("reset ready_o", {31'b0, ready_o}, 32'd1);

        // Streamed single-cycle ops, one result per cycle
        for (int i = 0; i <= NV; i++) begin
            if (i > 0) begin
                chk({vecs[i-1].name, " valid"}, {31'b0, valid_o}, 32'd1);
                chk({vecs[i-1].name, " r"}, r_o, vecs[i-1].r);
                chk({vecs[i-1].name, " nzcv"}, {28'b0, fl_o}, {28'b0, vecs[i-1].nzcv});
            end
            if (i < NV) begin
                valid_i = 1'b1;
                op_i = vecs[i].op; a_i = vecs[i].a; b_i = vecs[i].b; fl_i = vecs[i].fl;
                chk("stream ready_o", {31'b0, ready_o}, 32'd1);
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk);
        end
        chk("stream drained", {31'b0, valid_o}, 32'd0);

        mul_run(1'b0, 32);
        mul_run(1'b1, 8);

        // Backpressure: result held while ready_i is low
        ready_i = 1'b0; valid_i = 1'b1;
        op_i = OP_ADD; a_i = 32'd1; b_i = 32'd2; fl_i = 4'b0000;
        @(negedge clk);
        a_i = 32'd10; b_i = 32'd20;
        for (int i = 0; i < 5; i++) begin
            chk("hold valid_o", {31'b0, valid_o}, 32'd1);
            chk("hold r_o", r_o, 32'd3);
            chk("hold fl_o", {28'b0, fl_o}, 32'd0);
            chk("hold ready_o", {31'b0, ready_o}, 32'd0);
            @(negedge clk);
        end
        ready_i = 1'b1;
        #1;
        chk("release ready_o", {31'b0, ready_o}, 32'd1);
        @(negedge clk);
        chk("release next valid", {31'b0, valid_o}, 32'd1);
        chk("release next r", r_o, 32'd30);
        valid_i = 1'b0;
        @(negedge clk);
        chk("release drained", {31'b0, valid_o}, 32'd0);

        // Flush at multiplier cycle 10, with an op presented on the flush edge
        op_i = OP_MUL; a_i = 32'h0001_0000; b_i = 32'h0001_0003; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (9) @(negedge clk);
        chk("flush pre busy", {31'b0, ready_o}, 32'd0);
        flush_i = 1'b1; valid_i = 1'b1; op_i = OP_ADD; a_i = 32'd1; b_i = 32'd1;
        @(negedge clk);
        flush_i = 1'b0; valid_i = 1'b0;
        chk("flush valid_o", {31'b0, valid_o}, 32'd0);
        chk("flush idle", {31'b0, ready_o}, 32'd1);
        vseen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_o) vseen++;
        end
        chk("flush no result", vseen, 32'd0);

        // Asynchronous reset mid-multiply
        op_i = OP_MUL; a_i = 32'h0001_0000; b_i = 32'h0001_0003; fl_i = 4'b1111; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async rst valid_o", {31'b0, valid_o}, 32'd0);
        chk("async rst r_o", r_o, 32'd0);
        chk("async rst fl_o", {28'b0, fl_o}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        vseen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_o) vseen++;
        end
        chk("rst no result", vseen, 32'd0);
        chk("rst ready_o", {31'b0, ready_o}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
